// File: rtl/dht_scheduler.sv
// Request scheduler between a byte command channel, a DHT11 driver and a UART transmitter.
// Serves cached readings inside the minimum acquisition gap and runs an optional periodic report.
module dht_scheduler #(
    parameter int MIN_GAP_CYC     = 100000000,
    parameter int ACQ_TIMEOUT_CYC = 5000000,
    parameter int CONT_PERIOD_CYC = 150000000
) (
    input  logic        clk_50mhz,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [7:0]  req_cmd,
    output logic        dht_start,
    input  logic        dht_wait,
    input  logic        dht_error,
    input  logic [39:0] dht_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        cont_active,
    output logic [3:0]  dbg_state_o
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_START    = 4'd2;
    localparam logic [3:0] S_WAIT_HI  = 4'd3;
    localparam logic [3:0] S_WAIT_LO  = 4'd4;
    localparam logic [3:0] S_CHECK    = 4'd5;
    localparam logic [3:0] S_TX0      = 4'd6;
    localparam logic [3:0] S_TX0_DONE = 4'd7;
    localparam logic [3:0] S_TX1      = 4'd8;
    localparam logic [3:0] S_TX1_DONE = 4'd9;

    localparam logic [31:0] GAP      = 32'(MIN_GAP_CYC);
    localparam logic [31:0] TMO_LAST = 32'(ACQ_TIMEOUT_CYC - 1);
    localparam logic [31:0] PER_LAST = 32'(CONT_PERIOD_CYC - 1);

    logic [3:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_cmd_q, pend_cmd_d;
    logic        tick_pend_q, tick_pend_d;
    logic        cont_q, cont_d;
    logic        sel_hum_q, sel_hum_d;
    logic        cache_valid_q, cache_valid_d;
    logic [7:0]  hum_q, hum_d;
    logic [7:0]  temp_q, temp_d;
    logic [31:0] age_q, age_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] per_q, per_d;
    logic        err_q, err_d;
    logic [7:0]  val_q, val_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        dht_start_q, dht_start_d;

    logic        go_tx, tick, acq_to;
    logic [7:0]  rsp_code, rsp_val, sum;

    function automatic logic [15:0] read_rsp(input logic [7:0] cmd, input logic [7:0] hum,
                                             input logic [7:0] temp);
        case (cmd)
            8'h00:        read_rsp = 16'h0700;
            8'h01, 8'h03: read_rsp = {8'h09, temp};
            default:      read_rsp = {8'h08, hum};
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        pend_valid_d  = pend_valid_q;
        pend_cmd_d    = pend_cmd_q;
        cont_d        = cont_q;
        sel_hum_d     = sel_hum_q;
        cache_valid_d = cache_valid_q;
        hum_d         = hum_q;
        temp_d        = temp_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        val_d         = val_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = tx_start_q;
        dht_start_d   = dht_start_q;
        go_tx         = 1'b0;
        rsp_code      = 8'h00;
        rsp_val       = 8'h00;
        tick          = 1'b0;
        sum           = dht_data[39:32] + dht_data[31:24] + dht_data[23:16] + dht_data[15:8];
        acq_to        = (tmo_q >= TMO_LAST);
        age_d         = (age_q >= GAP) ? age_q : age_q + 32'd1;

        if (!cont_q) begin
            per_d = 32'd0;
        end else if (per_q >= PER_LAST) begin
            per_d = 32'd0;
            tick  = 1'b1;
        end else begin
            per_d = per_q + 32'd1;
        end
        tick_pend_d = tick_pend_q | tick;

        // Latest request wins while a transaction is in flight.
        if (req_valid && state_q != S_IDLE) begin
            pend_valid_d = 1'b1;
            pend_cmd_d   = req_cmd;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cmd_d        = req_cmd;
                    pend_valid_d = 1'b0;
                    state_d      = S_DECODE;
                end else if (pend_valid_q) begin
                    cmd_d        = pend_cmd_q;
                    pend_valid_d = 1'b0;
                    state_d      = S_DECODE;
                end else if (tick_pend_q) begin
                    cmd_d       = sel_hum_q ? 8'h02 : 8'h01;
                    tick_pend_d = tick;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cmd_q <= 8'h04) begin
                    if (cmd_q == 8'h03 || cmd_q == 8'h04) begin
                        cont_d      = 1'b1;
                        sel_hum_d   = (cmd_q == 8'h04);
                        per_d       = 32'd0;
                        tick_pend_d = 1'b0;
                    end
                    if (!cache_valid_q || age_q >= GAP) begin
                        state_d     = S_START;
                        tmo_d       = 32'd0;
                        dht_start_d = 1'b1;
                    end else begin
                        go_tx               = 1'b1;
                        {rsp_code, rsp_val} = read_rsp(cmd_q, hum_q, temp_q);
                    end
                end else if (cmd_q == 8'h05) begin
                    cont_d      = 1'b0;
                    per_d       = 32'd0;
                    tick_pend_d = 1'b0;
                    go_tx       = 1'b1;
                    rsp_code    = 8'h0A;
                end else begin
                    go_tx    = 1'b1;
                    rsp_code = 8'hFF;
                    rsp_val  = cmd_q;
                end
            end
            S_START, S_WAIT_HI, S_WAIT_LO: begin
                tmo_d = tmo_q + 32'd1;
                if (state_q == S_WAIT_LO && !dht_wait) begin
                    err_d   = dht_error;
                    state_d = S_CHECK;
                end else if (acq_to) begin
                    go_tx         = 1'b1;
                    rsp_code      = 8'h1F;
                    dht_start_d   = 1'b0;
                    cache_valid_d = 1'b0;
                end else if (state_q == S_WAIT_HI) begin
                    state_d = S_WAIT_LO;
                end else if (state_q == S_START && dht_wait) begin
                    dht_start_d = 1'b0;
                    state_d     = S_WAIT_HI;
                end
            end
            S_CHECK: begin
                go_tx = 1'b1;
                if (err_q || sum != dht_data[7:0]) begin
                    rsp_code = 8'h1F;
                end else begin
                    cache_valid_d       = 1'b1;
                    hum_d               = dht_data[39:32];
                    temp_d              = dht_data[23:16];
                    age_d               = 32'd0;
                    {rsp_code, rsp_val} = read_rsp(cmd_q, dht_data[39:32], dht_data[23:16]);
                end
            end
            S_TX0, S_TX1: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = (state_q == S_TX0) ? S_TX0_DONE : S_TX1_DONE;
                end
            end
            S_TX0_DONE: begin
                if (!tx_busy) begin
                    tx_data_d  = val_q;
                    tx_start_d = 1'b1;
                    state_d    = S_TX1;
                end
            end
            S_TX1_DONE: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (go_tx) begin
            state_d    = S_TX0;
            tx_data_d  = rsp_code;
            val_d      = rsp_val;
            tx_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= 8'h00;
            pend_valid_q  <= 1'b0;
            pend_cmd_q    <= 8'h00;
            tick_pend_q   <= 1'b0;
            cont_q        <= 1'b0;
            sel_hum_q     <= 1'b0;
            cache_valid_q <= 1'b0;
            hum_q         <= 8'h00;
            temp_q        <= 8'h00;
            age_q         <= 32'd0;
            tmo_q         <= 32'd0;
            per_q         <= 32'd0;
            err_q         <= 1'b0;
            val_q         <= 8'h00;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            dht_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            pend_valid_q  <= pend_valid_d;
            pend_cmd_q    <= pend_cmd_d;
            tick_pend_q   <= tick_pend_d;
            cont_q        <= cont_d;
            sel_hum_q     <= sel_hum_d;
            cache_valid_q <= cache_valid_d;
            hum_q         <= hum_d;
            temp_q        <= temp_d;
            age_q         <= age_d;
            tmo_q         <= tmo_d;
            per_q         <= per_d;
            err_q         <= err_d;
            val_q         <= val_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            dht_start_q   <= dht_start_d;
        end
    end

    assign dht_start   = dht_start_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = (state_q != S_IDLE);
    assign cont_active = cont_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/dht_scheduler.md
DHT_SCHEDULER -- requirements
Module: dht_scheduler

Interface
REQ-001 SHALL have parameter MIN_GAP_CYC, default 100000000, minimum cycles between two physical DHT11 acquisitions (2 s at 50 MHz).
REQ-002 SHALL have parameter ACQ_TIMEOUT_CYC, default 5000000, maximum cycles from dht_start assertion to dht_wait falling (100 ms).
REQ-003 SHALL have parameter CONT_PERIOD_CYC, default 150000000, auto-report period in continuous mode (3 s).
REQ-004 clk_50mhz  in  1  sole clock, 50 MHz.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req_valid  in  1  one-cycle strobe, a request byte is present.
REQ-007 req_cmd  in  8  request code.
REQ-008 dht_start  out  1  acquisition request to the DHT11 driver.
REQ-009 dht_wait  in  1  high while the DHT11 driver is acquiring.
REQ-010 dht_error  in  1  driver error flag, sampled when dht_wait falls.
REQ-011 dht_data  in  40  [39:32] hum int, [31:24] hum dec, [23:16] temp int, [15:8] temp dec, [7:0] checksum.
REQ-012 tx_data  out  8  byte to the UART transmitter.
REQ-013 tx_start  out  1  transmit request.
REQ-014 tx_busy  in  1  high while the transmitter shifts a byte.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 cont_active  out  1  continuous mode enabled.

Function
REQ-017 Commands SHALL be: 0x00 status, 0x01 temperature, 0x02 humidity, 0x03 continuous temperature, 0x04 continuous humidity, 0x05 stop continuous; any other code is invalid.
REQ-018 Every command SHALL produce exactly two response bytes, code then value: status ok {0x07,0x00}; temperature {0x09,temp int}; humidity {0x08,hum int}; sensor fault {0x1F,0x00}; stop {0x0A,0x00}; invalid {0xFF,req_cmd}.
REQ-019 FSM states SHALL be IDLE, DECODE, START, WAIT_HI, WAIT_LO, CHECK, TX0, TX0_DONE, TX1, TX1_DONE.
REQ-020 IDLE -> DECODE on req_valid, or on pending request, or on continuous-period expiry; priority: pending/new request over continuous tick.
REQ-021 DECODE: commands 0x00-0x04 go to START if cache invalid or age counter < MIN_GAP_CYC is false (age >= MIN_GAP_CYC), else to TX0 using cached data; 0x05 and invalid codes go to TX0.
REQ-022 START: dht_start held high until dht_wait observed high (-> WAIT_HI exit to WAIT_LO); dht_start SHALL drop the cycle after dht_wait is seen high.
REQ-023 WAIT_LO: on dht_wait falling -> CHECK; timeout counter started at START entry reaching ACQ_TIMEOUT_CYC -> fault response, dht_start deasserted, cache invalidated.
REQ-024 CHECK: fault if dht_error high or (sum of bytes [39:8] mod 256) != [7:0]; otherwise latch dht_data into cache, mark valid, clear age counter.
REQ-025 Age counter SHALL increment every cycle, saturating at MIN_GAP_CYC; a fault does not clear it (next request re-acquires only after MIN_GAP_CYC).
REQ-026 TXn: tx_data stable, tx_start held high until tx_busy high; TXn_DONE waits tx_busy low; tx_data SHALL NOT change between TXn entry and TXn_DONE exit.
REQ-027 0x03/0x04 SHALL set cont_active and select the reported value; 0x05 clears it; a fault does not clear it.
REQ-028 Continuous period counter SHALL run only while cont_active, reload on expiry, and a tick arriving while busy SHALL be held (one-deep) until IDLE.
REQ-029 req_valid while busy SHALL store req_cmd in a one-entry pending register; a newer request overwrites it (latest wins).
REQ-030 req_valid in IDLE coincident with a continuous tick: request served first, tick held.

Reset
REQ-031 On reset: state IDLE, dht_start 0, tx_start 0, tx_data 0x00, busy 0, cont_active 0, cache invalid, pending empty, all counters 0; reset mid-transaction SHALL abort it with no further bytes.

Verification
REQ-032 Reset, req 0x01, sensor model returns 0x3C00_1900_55 -> dht_start once, bytes 0x09 then 0x19.
REQ-033 Second req 0x02 within MIN_GAP_CYC -> no dht_start, bytes 0x08 then 0x3C from cache.
REQ-034 Checksum byte 0x00 on valid payload -> bytes 0x1F, 0x00; next read re-acquires after gap.
REQ-035 dht_wait stuck high -> after ACQ_TIMEOUT_CYC bytes 0x1F, 0x00, busy falls.
REQ-036 req 0x03 then 0x05 issued while busy, then 0x7E -> 0x7E pending overwrites 0x05: response {0xFF,0x7E}, cont_active stays 1, periodic {0x09,..} every CONT_PERIOD_CYC.
REQ-037 reset asserted during TX0_DONE -> tx_start 0 next cycle, no second byte, cont_active 0.
